// File: rtl/fft_addr_gen_pkg.sv
// Shared FSM encoding and width helper for the FFT address sequencer.
package fft_addr_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } fsm_t;

  // A counter that must count to v-1 still needs one bit when v <= 1.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/fft_addr_gen_bfly_idx.sv
// Butterfly index map for in-place radix-2 DIT: (j, s) -> operand and twiddle addresses.
module fft_addr_gen_bfly_idx #(
  parameter int AWL = 3,
  parameter int SWL = 3
) (
  input  logic [AWL-1:0] j,
  input  logic [SWL-1:0] s,
  output logic [AWL:0]   addr_a,
  output logic [AWL:0]   addr_b,
  output logic [AWL-1:0] tw_addr
);

  localparam logic [AWL:0]   ONE  = 1;
  localparam logic [SWL-1:0] SAWL = SWL'(AWL);

  logic [AWL:0] jw, half, mask;

  always_comb begin
    jw      = {1'b0, j};
    half    = ONE << s;
    mask    = half - ONE;
    // Bits at and above s move up by one, leaving a zero at position s.
    addr_a  = ((jw & ~mask) << 1) | (jw & mask);
    addr_b  = addr_a | half;
    tw_addr = AWL'((jw & mask) << (SAWL - s));
  end

endmodule

// File: rtl/fft_addr_gen.sv
// Stage/butterfly sequencer for in-place radix-2 DIT FFT with ready/valid hold and inter-stage bubbles.
module fft_addr_gen
  import fft_addr_gen_pkg::*;
#(
  parameter int AWL       = 3,
  parameter int STAGE_GAP = 2,
  parameter int SWL       = 3
) (
  input  logic           i_CLK,
  input  logic           i_RESET,
  input  logic           i_START,
  input  logic           i_READY,
  output logic           o_VALID,
  output logic [AWL:0]   o_ADDR_A,
  output logic [AWL:0]   o_ADDR_B,
  output logic [AWL-1:0] o_TW_ADDR,
  output logic [SWL-1:0] o_STAGE,
  output logic           o_LAST,
  output logic           o_BUSY,
  output logic           o_DONE
);

  localparam int             GW   = clog2_min1(STAGE_GAP);
  localparam logic [AWL-1:0] JMAX = '1;
  localparam logic [SWL-1:0] SMAX = SWL'(AWL);

  fsm_t           st, st_nx;
  logic [AWL-1:0] j, j_nx;
  logic [SWL-1:0] s, s_nx;
  logic [GW-1:0]  gcnt, gcnt_nx;
  logic           vld_nx, load;
  logic           xfer, stage_end, gap_end;
  logic [AWL:0]   a_nx, b_nx;
  logic [AWL-1:0] tw_nx;

  assign xfer      = o_VALID & i_READY;
  assign stage_end = (j == JMAX);
  assign gap_end   = (int'(gcnt) == STAGE_GAP - 1);

  // Addresses are computed from the next (j, s) so the output registers line up with o_VALID.
  fft_addr_gen_bfly_idx #(.AWL(AWL), .SWL(SWL)) u_idx (
    .j       (j_nx),
    .s       (s_nx),
    .addr_a  (a_nx),
    .addr_b  (b_nx),
    .tw_addr (tw_nx)
  );

  always_comb begin
    st_nx   = st;
    j_nx    = j;
    s_nx    = s;
    gcnt_nx = gcnt;
    vld_nx  = o_VALID;
    load    = 1'b0;
    case (st)
      ST_IDLE: if (i_START) begin
        st_nx  = ST_RUN;
        j_nx   = '0;
        s_nx   = '0;
        vld_nx = 1'b1;
        load   = 1'b1;
      end
      ST_RUN: if (xfer) begin
        if (!stage_end) begin
          j_nx = j + AWL'(1);
          load = 1'b1;
        end else if (s == SMAX) begin
          st_nx  = ST_DONE;
          vld_nx = 1'b0;
        end else begin
          j_nx = '0;
          s_nx = s + SWL'(1);
          if (STAGE_GAP == 0) begin
            load = 1'b1;
          end else begin
            st_nx   = ST_GAP;
            gcnt_nx = '0;
            vld_nx  = 1'b0;
          end
        end
      end
      // (j, s) already point at the next stage's first butterfly while draining.
      ST_GAP: if (gap_end) begin
        st_nx  = ST_RUN;
        vld_nx = 1'b1;
        load   = 1'b1;
      end else begin
        gcnt_nx = gcnt + GW'(1);
      end
      ST_DONE: st_nx = ST_IDLE;
      default: st_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      st        <= ST_IDLE;
      j         <= '0;
      s         <= '0;
      gcnt      <= '0;
      o_VALID   <= 1'b0;
      o_ADDR_A  <= '0;
      o_ADDR_B  <= '0;
      o_TW_ADDR <= '0;
      o_STAGE   <= '0;
      o_LAST    <= 1'b0;
      o_BUSY    <= 1'b0;
      o_DONE    <= 1'b0;
    end else begin
      st      <= st_nx;
      j       <= j_nx;
      s       <= s_nx;
      gcnt    <= gcnt_nx;
      o_VALID <= vld_nx;
      o_LAST  <= vld_nx & (j_nx == JMAX);
      o_BUSY  <= (st_nx != ST_IDLE);
      o_DONE  <= (st_nx == ST_DONE);
      if (load) begin
        o_ADDR_A  <= a_nx;
        o_ADDR_B  <= b_nx;
        o_TW_ADDR <= tw_nx;
        o_STAGE   <= s_nx;
      end
    end
  end

endmodule
